// File: rtl/car_lane_engine_pkg.sv
// rtl/car_lane_engine_pkg.sv - shared geometry constants and helpers for the car lane engine
package car_lane_engine_pkg;
  localparam int H_DISPLAY      = 640;
  localparam int CAR_WIDTH      = 32;
  localparam int CAR_HEIGHT     = 16;
  localparam int PLAYER_WIDTH   = 16;
  localparam int PLAYER_HEIGHT  = 16;
  localparam int LANE_Y0        = 320;
  localparam int LANE_PITCH     = 32;
  localparam int NUM_LANES_DEF  = 4;
  localparam int CARS_DEF       = 2;
  localparam int LANE_W         = (NUM_LANES_DEF > 1) ? $clog2(NUM_LANES_DEF) : 1;

  typedef logic [9:0] coord_t;
  typedef logic [LANE_W-1:0] lane_idx_t;

  // Cars of a lane are spread evenly; lane l is shifted so lanes do not line up.
  function automatic int reset_x(int lane, int car, int offset, int cars);
    return (lane * offset + car * H_DISPLAY / cars) % H_DISPLAY;
  endfunction
endpackage

// File: rtl/car_lane_engine_if.sv
// rtl/car_lane_engine_if.sv - video timing in, per-pixel car answer out
interface car_lane_engine_if;
  import car_lane_engine_pkg::*;
  logic      frame_start;
  coord_t    h_count;
  coord_t    v_count;
  logic      pixel_car;
  lane_idx_t pixel_lane;

  modport master (output frame_start, h_count, v_count, input pixel_car, pixel_lane);
  modport slave  (input frame_start, h_count, v_count, output pixel_car, pixel_lane);
endinterface

// File: rtl/car_lane_engine_car_lane.sv
// rtl/car_lane_engine_car_lane.sv - one lane: frame divider, car positions, wrap adder, hit test
module car_lane_engine_car_lane
  import car_lane_engine_pkg::*;
#(
  parameter int LANE      = 0,
  parameter int CARS      = 2,
  parameter int PERIOD    = 2,
  parameter int OFFSET    = 100,
  parameter int Y_TOP     = 320,
  parameter bit MOVE_LEFT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [8:0] step,
  input  coord_t     h,
  input  coord_t     v,
  output logic       hit
);
  localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [DIV_W-1:0] div;
  logic             move;
  logic             in_row;
  logic [CARS-1:0]  car_hit;

  assign move = frame_start && enable && (div == DIV_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    div <= '0;
    else if (frame_start && enable) div <= move ? '0 : div + 1'b1;
  end

  for (genvar k = 0; k < CARS; k++) begin : g_car
    localparam coord_t X0 = coord_t'(reset_x(LANE, k, OFFSET, CARS));
    coord_t      x;
    logic [10:0] t;
    logic [10:0] nx;
    logic [10:0] d;

    always_comb begin
      t  = {1'b0, x} + {2'b0, step};
      nx = t;
      if (MOVE_LEFT)
        nx = ({1'b0, x} < {2'b0, step}) ? {1'b0, x} + 11'(H_DISPLAY) - {2'b0, step}
                                        : {1'b0, x} - {2'b0, step};
      else if (t >= 11'(H_DISPLAY))
        nx = t - 11'(H_DISPLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    x <= X0;
      else if (move) x <= nx[9:0];
    end

    // Distance from car nose to pixel modulo the screen width, so tails wrap to the left edge.
    always_comb begin
      d = (h >= x) ? {1'b0, h} - {1'b0, x} : {1'b0, h} + 11'(H_DISPLAY) - {1'b0, x};
    end
    assign car_hit[k] = (d < 11'(CAR_WIDTH));
  end

  assign in_row = ({1'b0, v} >= 11'(Y_TOP)) && ({1'b0, v} < 11'(Y_TOP + CAR_HEIGHT)) &&
                  ({1'b0, h} < 11'(H_DISPLAY));
  assign hit    = in_row && (|car_hit);
endmodule

// File: rtl/car_lane_engine.sv
// rtl/car_lane_engine.sv - multi-lane traffic generator with pixel query and per-frame collision pulse
module car_lane_engine
  import car_lane_engine_pkg::*;
#(
  parameter int                     NUM_LANES     = NUM_LANES_DEF,
  parameter int                     CARS_PER_LANE = CARS_DEF,
  parameter int                     LANE_PERIOD   = 2,
  parameter logic [8*NUM_LANES-1:0] LANE_STEP     = {8'd20, 8'd32, 8'd20, 8'd32},
  parameter logic [NUM_LANES-1:0]   DIR_MASK      = 4'b1010,
  parameter int                     LANE_OFFSET   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] level,
  input  coord_t     player_x,
  input  coord_t     player_y,
  output logic       collision,
  car_lane_engine_if.slave vid
);
  logic [NUM_LANES-1:0] lane_hit;
  lane_idx_t            lane_idx;
  logic                 in_player;
  logic                 overlap;
  logic                 flag;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [8:0] step;
    assign step = {1'b0, LANE_STEP[8*l +: 8]} + {6'b0, level};

    car_lane_engine_car_lane #(
      .LANE      (l),
      .CARS      (CARS_PER_LANE),
      .PERIOD    (LANE_PERIOD),
      .OFFSET    (LANE_OFFSET),
      .Y_TOP     (LANE_Y0 + l * LANE_PITCH),
      .MOVE_LEFT (DIR_MASK[l])
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (vid.frame_start),
      .enable      (enable),
      .step        (step),
      .h           (vid.h_count),
      .v           (vid.v_count),
      .hit         (lane_hit[l])
    );
  end

  // Lowest lane index wins when rows overlap.
  always_comb begin
    lane_idx = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--)
      if (lane_hit[l]) lane_idx = LANE_W'(l);
  end

  assign in_player = ({1'b0, vid.h_count} >= {1'b0, player_x}) &&
                     ({1'b0, vid.h_count} <  {1'b0, player_x} + 11'(PLAYER_WIDTH)) &&
                     ({1'b0, vid.v_count} >= {1'b0, player_y}) &&
                     ({1'b0, vid.v_count} <  {1'b0, player_y} + 11'(PLAYER_HEIGHT));
  assign overlap   = (|lane_hit) && in_player;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.pixel_car  <= 1'b0;
      vid.pixel_lane <= '0;
      collision      <= 1'b0;
      flag           <= 1'b0;
    end else begin
      vid.pixel_car  <= |lane_hit;
      vid.pixel_lane <= lane_idx;
      if (vid.frame_start) begin
        collision <= flag;
        flag      <= overlap;
      end else begin
        collision <= 1'b0;
        if (overlap) flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_car_lane_engine.sv
// tb/tb_car_lane_engine.sv - randomized bench against a frame-level traffic model
module tb_car_lane_engine;
  import car_lane_engine_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable;
  logic [2:0] level;
  coord_t     player_x, player_y;
  logic       collision;
  int         n_checks = 0;
  int         n_errors = 0;

  car_lane_engine_if vid ();

  car_lane_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .level     (level),
    .player_x  (player_x),
    .player_y  (player_y),
    .collision (collision),
    .vid       (vid)
  );

  always #5 clk = ~clk;

  // Model: car positions in screen space, one frame counter shared by all lanes.
  int step_tab [4] = '{32, 20, 32, 20};
  bit left_tab [4] = '{0, 1, 0, 1};
  int mpos [4][2];
  int mframes;
  bit mflag;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 2; k++)
        mpos[l][k] = (l * 100 + k * 320) % 640;
    mframes = 0;
    mflag   = 0;
  endtask

  function automatic bit model_hit(input int h, input int v, output int lane);
    lane = 0;
    if (h >= 640) return 0;
    for (int l = 0; l < 4; l++) begin
      if (v >= 320 + 32 * l && v < 320 + 32 * l + 16)
        for (int k = 0; k < 2; k++)
          if ((((h - mpos[l][k]) % 640) + 640) % 640 < 32) begin
            lane = l;
            return 1;
          end
    end
    return 0;
  endfunction

  task automatic cyc(input bit fs, input bit en, input int lv, input int h, input int v,
                     input int px, input int py);
    int ln, ecoll, s;
    bit hit, ov;
    vid.frame_start = fs;
    enable          = en;
    level           = 3'(lv);
    vid.h_count     = 10'(h);
    vid.v_count     = 10'(v);
    player_x        = 10'(px);
    player_y        = 10'(py);
    hit = model_hit(h, v, ln);
    ov  = hit && h >= px && h < px + 16 && v >= py && v < py + 16;
    if (fs) begin
      ecoll = mflag;
      mflag = ov;
    end else begin
      ecoll = 0;
      mflag = mflag | ov;
    end
    if (fs && en) begin
      mframes++;
      if (mframes == 2) begin
        mframes = 0;
        for (int l = 0; l < 4; l++) begin
          s = step_tab[l] + lv;
          for (int k = 0; k < 2; k++)
            mpos[l][k] = left_tab[l] ? (mpos[l][k] - s + 640) % 640 : (mpos[l][k] + s) % 640;
        end
      end
    end
    @(posedge clk);
    #2;
    check_val("pixel_car", int'(vid.pixel_car), int'(hit));
    if (hit) check_val("pixel_lane", int'(vid.pixel_lane), ln);
    check_val("collision", int'(collision), ecoll);
    @(negedge clk);
  endtask

  initial begin
    int px, py, h, v;
    bit en;
    vid.frame_start = 0; vid.h_count = '0; vid.v_count = '0;
    enable = 0; level = '0; player_x = '0; player_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_pixel_car", int'(vid.pixel_car), 0);
    check_val("rst_pixel_lane", int'(vid.pixel_lane), 0);
    check_val("rst_collision", int'(collision), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset positions and car/row edges.
    cyc(0, 0, 0, 0,   320, 600, 0);
    cyc(0, 0, 0, 330, 325, 600, 0);
    cyc(0, 0, 0, 100, 352, 600, 0);
    cyc(0, 0, 0, 31,  335, 600, 0);
    cyc(0, 0, 0, 32,  320, 600, 0);
    cyc(0, 0, 0, 10,  336, 600, 0);
    cyc(0, 0, 0, 700, 320, 600, 0);
    cyc(0, 0, 0, 99,  352, 600, 0);

    // Collision pulse, clear, and same-cycle frame_start with overlap.
    cyc(0, 0, 0, 6,   322, 4, 320);
    cyc(1, 0, 0, 500, 0,   4, 320);
    cyc(1, 0, 0, 500, 0,   4, 320);
    cyc(1, 0, 0, 6,   322, 4, 320);
    cyc(1, 0, 0, 500, 0,   4, 320);
    cyc(1, 0, 0, 500, 0,   4, 320);

    // Asynchronous reset while pixel_car and collision are both high.
    cyc(0, 0, 0, 6, 322, 4, 320);
    cyc(1, 0, 0, 6, 322, 4, 320);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_pixel_car", int'(vid.pixel_car), 0);
    check_val("async_collision", int'(collision), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Frozen traffic for a stretch, then random motion with wrap, levels and collisions.
    px = 300; py = 330;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        px = $urandom_range(0, 630);
        py = $urandom_range(310, 430);
      end
      en = (i % 400) >= 80;
      if ($urandom_range(0, 9) < 3) begin
        h = px + $urandom_range(0, 15);
        v = py + $urandom_range(0, 15);
      end else begin
        h = $urandom_range(0, 700);
        v = ($urandom_range(0, 9) < 7) ? $urandom_range(316, 436) : $urandom_range(0, 479);
      end
      cyc($urandom_range(0, 5) == 0, en, $urandom_range(0, 7), h, v, px, py);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
